// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fixed-latency instruction fetch sequencer between the IF stage and an
// async-read instruction memory. Define FETCH_PREFETCH_EN to add a one-entry next-line prefetch buffer.
module imem_fetch_ctrl #(
   parameter int unsigned MEM_LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_inst,
   output logic [31:0] resp_addr,
   input  logic        resp_ready,
   input  logic        flush,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic        busy
);
   localparam int unsigned     CW       = $clog2(MEM_LATENCY + 1);
   localparam logic [CW-1:0]   CNT_INIT = CW'(MEM_LATENCY - 1);
   localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
`ifdef FETCH_PREFETCH_EN
      PREF = 2'd3,
`endif
      RESP = 2'd2
   } state_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [31:0]   mem_addr_n, resp_inst_n, resp_addr_n, req_word;
   logic          ready_c, valid_c;
`ifdef FETCH_PREFETCH_EN
   logic          pf_valid, pf_valid_n;
   logic [31:0]   pf_addr, pf_addr_n, pf_data, pf_data_n, next_line;
   assign next_line = resp_addr + 32'd4;
`endif

   assign req_word   = word_align(req_addr);
   assign req_ready  = ready_c & ~reset;
   assign resp_valid = valid_c & ~reset;
   assign busy       = (state != IDLE);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= CNT_ZERO;
         mem_addr  <= 32'h0000_0000;
         resp_inst <= 32'h0000_0000;
         resp_addr <= 32'h0000_0000;
`ifdef FETCH_PREFETCH_EN
         pf_valid  <= 1'b0;
         pf_addr   <= 32'h0000_0000;
         pf_data   <= 32'h0000_0000;
`endif
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         mem_addr  <= mem_addr_n;
         resp_inst <= resp_inst_n;
         resp_addr <= resp_addr_n;
`ifdef FETCH_PREFETCH_EN
         pf_valid  <= pf_valid_n;
         pf_addr   <= pf_addr_n;
         pf_data   <= pf_data_n;
`endif
      end
   end

   // Next-state, handshake and datapath update logic
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      mem_addr_n  = mem_addr;
      resp_inst_n = resp_inst;
      resp_addr_n = resp_addr;
      ready_c     = 1'b0;
      valid_c     = 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_valid_n  = pf_valid;
      pf_addr_n   = pf_addr;
      pf_data_n   = pf_data;
`endif
      case (state)
         IDLE: ready_c = 1'b1;
         WAIT: begin
            if (cnt != CNT_ZERO) begin
               cnt_n = cnt - CNT_ONE;
            end else begin
               resp_inst_n = mem_dout;
               resp_addr_n = mem_addr;
               state_n     = RESP;
            end
         end
         RESP: begin
            valid_c = 1'b1;
            if (resp_ready) begin
               ready_c = 1'b1;
               state_n = IDLE;
`ifdef FETCH_PREFETCH_EN
               // Next line already buffered: no point re-reading it
               if (!(pf_valid && (pf_addr == next_line))) begin
                  mem_addr_n = next_line;
                  cnt_n      = CNT_INIT;
                  state_n    = PREF;
               end else begin
                  state_n    = IDLE;
               end
`endif
            end else begin
               state_n = RESP;
            end
         end
`ifdef FETCH_PREFETCH_EN
         PREF: begin
            ready_c = 1'b1;
            if (cnt != CNT_ZERO) begin
               cnt_n = cnt - CNT_ONE;
            end else begin
               pf_valid_n = 1'b1;
               pf_addr_n  = mem_addr;
               pf_data_n  = mem_dout;
               state_n    = IDLE;
            end
         end
`endif
         default: begin
            state_n = IDLE;
            cnt_n   = CNT_ZERO;
         end
      endcase

      if (flush) begin
         ready_c = 1'b0;
         valid_c = 1'b0;
         state_n = IDLE;
         cnt_n   = CNT_ZERO;
`ifdef FETCH_PREFETCH_EN
         pf_valid_n = 1'b0;
`endif
      end else if (req_valid && ready_c) begin
         mem_addr_n = req_word;
`ifdef FETCH_PREFETCH_EN
         // A request hitting the line being prefetched turns it into the demand fetch
         if ((state == PREF) && (req_word == mem_addr)) begin
            pf_valid_n = pf_valid;
            pf_addr_n  = pf_addr;
            pf_data_n  = pf_data;
            if (cnt == CNT_ZERO) begin
               resp_inst_n = mem_dout;
               resp_addr_n = mem_addr;
               state_n     = RESP;
            end else begin
               state_n     = WAIT;
            end
         end else if (pf_valid && (req_word == pf_addr)) begin
            resp_inst_n = pf_data;
            resp_addr_n = pf_addr;
            pf_valid_n  = 1'b0;
            cnt_n       = CNT_ZERO;
            state_n     = RESP;
         end else begin
            cnt_n   = CNT_INIT;
            state_n = WAIT;
         end
`else
         cnt_n   = CNT_INIT;
         state_n = WAIT;
`endif
      end else begin
         mem_addr_n = mem_addr_n;
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with MEM_LATENCY=4. Memory word at address A
// is modelled as {~A[15:0], A[15:0]}; buffer-hit latencies follow FETCH_PREFETCH_EN.
module tb_imem_fetch_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_inst;
   logic [31:0] resp_addr;
   logic        resp_ready;
   logic        flush;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic        busy;

   int checks   = 0;
   int failures = 0;

`ifdef FETCH_PREFETCH_EN
   localparam int          HIT_LAT   = 1;
   localparam logic [31:0] WRAP_MA   = 32'h0000_0000;
   localparam logic [31:0] POST_BUSY = 32'd1;
`else
   localparam int          HIT_LAT   = 5;
   localparam logic [31:0] WRAP_MA   = 32'hFFFF_FFFC;
   localparam logic [31:0] POST_BUSY = 32'd0;
`endif

   always #5 clk = ~clk;

   assign mem_dout = {~mem_addr[15:0], mem_addr[15:0]};

   imem_fetch_ctrl #(.MEM_LATENCY(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_inst  (resp_inst),
      .resp_addr  (resp_addr),
      .resp_ready (resp_ready),
      .flush      (flush),
      .mem_addr   (mem_addr),
      .mem_dout   (mem_dout),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Starts right after the accept edge; ends at the negedge of the first resp_valid cycle.
   task automatic wait_resp(input logic [31:0] ea, input logic [31:0] ei, input int el);
      int lat;
      lat = 0;
      for (int i = 1; (i <= 20) && (lat == 0); i++) begin
         @(negedge clk);
         chk("busy_inflight", {31'd0, busy}, 32'd1);
         if (resp_valid) begin
            lat = i;
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("latency", lat, el);
      chk("resp_addr", resp_addr, ea);
      chk("resp_inst", resp_inst, ei);
   endtask

   task automatic do_fetch(input logic [31:0] a, input logic [31:0] ea, input logic [31:0] ei,
                           input int el);
      req_valid  = 1'b1;
      req_addr   = a;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("accept_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_resp(ea, ei, el);
   endtask

   task automatic release_resp();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic flush_cycle();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "bench timeout");
   end

   initial begin
      int hits;
      reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_resp_inst", resp_inst, 32'h0);
      chk("rst_resp_addr", resp_addr, 32'h0);
      @(posedge clk); #1;

      // Basic fetch, then hold the response for three cycles and chain a back-to-back request
      do_fetch(32'h0000_0100, 32'h0000_0100, 32'hFEFF_0100, 5);
      chk("t1_mem_addr", mem_addr, 32'h0000_0100);
      req_valid = 1'b1;
      req_addr  = 32'h0000_0104;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_valid", {31'd0, resp_valid}, 32'd1);
         chk("hold_addr", resp_addr, 32'h0000_0100);
         chk("hold_inst", resp_inst, 32'hFEFF_0100);
         chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      #1;
      chk("b2b_req_ready", {31'd0, req_ready}, 32'd1);
      chk("b2b_resp_valid", {31'd0, resp_valid}, 32'd1);
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      @(negedge clk);
      chk("b2b_mem_addr", mem_addr, 32'h0000_0104);
      chk("b2b_resp_gone", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      wait_resp(32'h0000_0104, 32'hFEFB_0104, 4);
      release_resp();
      @(negedge clk);
      chk("post_hs_busy", {31'd0, busy}, POST_BUSY);
      @(posedge clk); #1;
      flush_cycle();

      // Flush while WAIT has cnt=2: fetch is dropped for good
      req_valid = 1'b1;
      req_addr  = 32'h0000_0180;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
      chk("flush_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("after_flush_busy", {31'd0, busy}, 32'd0);
      chk("after_flush_ready", {31'd0, req_ready}, 32'd1);
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (resp_valid) hits++;
      end
      chk("flushed_no_resp", hits, 0);
      do_fetch(32'h0000_0200, 32'h0000_0200, 32'hFDFF_0200, 5);

      // Flush coincident with response handshake and a new request
      flush = 1'b1; resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_0240;
      #1;
      chk("fhs_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("fhs_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; resp_ready = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("fhs_busy", {31'd0, busy}, 32'd0);
      chk("fhs_resp_valid2", {31'd0, resp_valid}, 32'd0);
      chk("fhs_mem_addr", mem_addr, 32'h0000_0200);
      @(posedge clk); #1;

      // Address wrap at the top of the address space
      do_fetch(32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0003_FFFC, 5);
      chk("wrap_mem_addr", mem_addr, 32'hFFFF_FFFC);
      release_resp();
      @(negedge clk);
      chk("wrap_next_line", mem_addr, WRAP_MA);
      @(posedge clk); #1;
      idle(6);
      do_fetch(32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000, HIT_LAT);
      release_resp();
      flush_cycle();

      // Next-line sequence, then a different request while the next prefetch is in flight
      do_fetch(32'h0000_0100, 32'h0000_0100, 32'hFEFF_0100, 5);
      release_resp();
      idle(6);
      @(negedge clk);
      chk("pf_idle_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      do_fetch(32'h0000_0104, 32'h0000_0104, 32'hFEFB_0104, HIT_LAT);
      release_resp();
      do_fetch(32'h0000_0300, 32'h0000_0300, 32'hFCFF_0300, 5);
      chk("abort_mem_addr", mem_addr, 32'h0000_0300);
      release_resp();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
